// File: rtl/pbit_anneal_scheduler.sv
// Annealing controller: steps beta from start to end with a programmable dwell and captures one
// (m_0, m_1) sample per dwell. Define PBIT_ANNEAL_AGREE_CNT_EN to add the m_0==m_1 agreement counters.
module pbit_anneal_scheduler #(
  parameter int unsigned M      = 8,
  parameter int unsigned BETA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk_mac,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic signed [BETA_W-1:0] i_beta_start,
  input  logic signed [BETA_W-1:0] i_beta_end,
  input  logic signed [BETA_W-1:0] i_beta_step,
  input  logic [CNT_W-1:0]         i_dwell,
  input  logic [M-1:0]             i_m_0,
  input  logic [M-1:0]             i_m_1,
  input  logic                     i_core_running,
  input  logic                     i_core_done,
  output logic                     o_run,
  output logic                     o_stop,
  output logic signed [BETA_W-1:0] o_beta,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_aborted,
  output logic                     o_sample_valid,
  output logic [M-1:0]             o_sample_0,
  output logic [M-1:0]             o_sample_1,
  output logic [CNT_W-1:0]         o_sample_cnt
`ifdef PBIT_ANNEAL_AGREE_CNT_EN
  ,
  output logic [CNT_W-1:0]         o_agree_cnt,
  output logic                     o_agree_last
`endif
);
  localparam int unsigned EXT_W = BETA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_ANNEAL, S_STOP, S_WAIT_DONE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [BETA_W-1:0] beta_q, beta_d, end_q, end_d, step_q, step_d, beta_out_d;
  logic [CNT_W-1:0]         dwell_q, dwell_d, cnt_q, cnt_d, scnt_d;
  logic                     run_d, stop_d, busy_d, done_d, aborted_d, valid_d;
  logic [M-1:0]             s0_d, s1_d;

  logic signed [EXT_W-1:0]  sum_c, end_ext_c;
  logic signed [BETA_W-1:0] beta_next_c;
  logic                     step_pos_c, step_neg_c, final_c, dwell_end_c;

`ifdef PBIT_ANNEAL_AGREE_CNT_EN
  logic [CNT_W-1:0] agree_cnt_d;
  logic             agree_last_d;
`endif

  // Next beta computed one bit wider so the clamp against end cannot wrap
  always_comb begin
    sum_c       = $signed({beta_q[BETA_W-1], beta_q}) + $signed({step_q[BETA_W-1], step_q});
    end_ext_c   = $signed({end_q[BETA_W-1], end_q});
    step_neg_c  = step_q[BETA_W-1];
    step_pos_c  = !step_neg_c && (step_q != '0);
    final_c     = (step_q == '0) || (step_pos_c && (beta_q >= end_q)) ||
                  (step_neg_c && (beta_q <= end_q));
    if ((step_pos_c && (sum_c > end_ext_c)) || (step_neg_c && (sum_c < end_ext_c)))
      beta_next_c = end_q;
    else
      beta_next_c = sum_c[BETA_W-1:0];
    dwell_end_c = (cnt_q == dwell_q - CNT_W'(1));
  end

  // Next-state and next-output logic; o_beta trails the working beta by one cycle
  always_comb begin
    state_d    = state_q;
    beta_d     = beta_q;
    end_d      = end_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    beta_out_d = beta_q;
    run_d      = o_run;
    stop_d     = 1'b0;
    done_d     = 1'b0;
    aborted_d  = o_aborted;
    valid_d    = 1'b0;
    s0_d       = o_sample_0;
    s1_d       = o_sample_1;
    scnt_d     = o_sample_cnt;
`ifdef PBIT_ANNEAL_AGREE_CNT_EN
    agree_cnt_d  = o_agree_cnt;
    agree_last_d = o_agree_last;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          end_d      = i_beta_end;
          step_d     = i_beta_step;
          dwell_d    = (i_dwell == '0) ? CNT_W'(1) : i_dwell;
          beta_d     = i_beta_start;
          beta_out_d = i_beta_start;
          scnt_d     = '0;
          aborted_d  = 1'b0;
          run_d      = 1'b1;
          state_d    = S_LAUNCH;
`ifdef PBIT_ANNEAL_AGREE_CNT_EN
          agree_cnt_d  = '0;
          agree_last_d = 1'b0;
`endif
        end
      end
      S_LAUNCH: begin
        if (i_abort) begin
          run_d     = 1'b0;
          stop_d    = 1'b1;
          aborted_d = 1'b1;
          state_d   = S_STOP;
        end else if (i_core_running) begin
          run_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_ANNEAL;
        end
      end
      S_ANNEAL: begin
        if (i_abort) begin
          stop_d    = 1'b1;
          aborted_d = 1'b1;
          state_d   = S_STOP;
        end else if (dwell_end_c) begin
          valid_d = 1'b1;
          s0_d    = i_m_0;
          s1_d    = i_m_1;
          cnt_d   = '0;
          if (o_sample_cnt != '1) scnt_d = o_sample_cnt + CNT_W'(1);
`ifdef PBIT_ANNEAL_AGREE_CNT_EN
          agree_last_d = (i_m_0 == i_m_1);
          if ((i_m_0 == i_m_1) && (o_agree_cnt != '1)) agree_cnt_d = o_agree_cnt + CNT_W'(1);
`endif
          if (final_c) begin
            stop_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            beta_d = beta_next_c;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        done_d  = i_core_done;
        state_d = i_core_done ? S_DONE : S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_core_done) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_mac or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      beta_q         <= '0;
      end_q          <= '0;
      step_q         <= '0;
      dwell_q        <= '0;
      cnt_q          <= '0;
      o_run          <= 1'b0;
      o_stop         <= 1'b0;
      o_beta         <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_aborted      <= 1'b0;
      o_sample_valid <= 1'b0;
      o_sample_0     <= '0;
      o_sample_1     <= '0;
      o_sample_cnt   <= '0;
`ifdef PBIT_ANNEAL_AGREE_CNT_EN
      o_agree_cnt    <= '0;
      o_agree_last   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      beta_q         <= beta_d;
      end_q          <= end_d;
      step_q         <= step_d;
      dwell_q        <= dwell_d;
      cnt_q          <= cnt_d;
      o_run          <= run_d;
      o_stop         <= stop_d;
      o_beta         <= beta_out_d;
      o_busy         <= busy_d;
      o_done         <= done_d;
      o_aborted      <= aborted_d;
      o_sample_valid <= valid_d;
      o_sample_0     <= s0_d;
      o_sample_1     <= s1_d;
      o_sample_cnt   <= scnt_d;
`ifdef PBIT_ANNEAL_AGREE_CNT_EN
      o_agree_cnt    <= agree_cnt_d;
      o_agree_last   <= agree_last_d;
`endif
    end
  end
endmodule
